// File: rtl/icb_pkg.sv
// Shared ICB definitions for the one-to-N dispatcher: field widths, the
// routing-FIFO entry layout and the window-decode helper.
package icb_pkg;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int MASK_W       = 4;
   localparam int MAX_MASTER_N = 8;
   localparam int TGT_W        = 3;
   localparam int ROUTE_W      = 4;

   // Stall-compare key for the internal error slave; sits just past the
   // highest real master index so it never aliases a downstream port.
   localparam logic [ROUTE_W-1:0] ERR_TGT = 4'd8;

   // One routing-FIFO entry: who owes the response for an accepted command.
   typedef struct packed {
      logic             is_err;
      logic [TGT_W-1:0] tgt_idx;
   } route_entry_t;

   // Window hit in 33-bit arithmetic so a window ending exactly at 2^32
   // (e.g. base 0xFFFF_F000, range 0x1000) still decodes.
   function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] range);
      logic [ADDR_W:0] a;
      logic [ADDR_W:0] lo;
      logic [ADDR_W:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + {1'b0, range};
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/icb_route_fifo.sv
// First-word-fall-through routing FIFO. Holds one route entry per
// outstanding command; the head entry steers the response path.
module icb_route_fifo #(
   parameter int depth = 4,
   parameter int width = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     wen,
   input  logic [width-1:0]         din,
   output logic                     full_n,
   input  logic                     ren,
   output logic [width-1:0]         dout,
   output logic                     empty_n,
   output logic [$clog2(depth):0]   count
);

   localparam int PTR_W = $clog2(depth);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(depth);

   logic [width-1:0] mem [depth];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             push;
   logic             pop;

   // A push is refused whenever the FIFO is full, even if a pop happens in
   // the same cycle: the full flag comes straight from the registered count.
   assign full_n  = (count < DEPTH_C);
   assign empty_n = (count != '0);
   assign push    = wen & full_n;
   assign pop     = ren & empty_n;
   assign dout    = mem[rptr];

   // Entry storage, written at the tail on every accepted push.
   // NOTE: storage has no reset; entries are only ever read behind a valid
   // count, so clearing them would add reset fan-out for no behaviour.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= din;
      end
   end

   // Pointer and occupancy tracking; depth is a power of two so the
   // pointers wrap on their own.
   // NOTE: state uses non-blocking assignments so every register in the
   // block samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/icb_1s_to_nm.sv
// ICB one-slave-port to N-master-port dispatcher. Decodes the command
// address against per-master windows, forwards the command with zero
// latency, records the target in a routing FIFO and returns responses in
// command order. Decode misses are answered by an internal error slave.
module icb_1s_to_nm
   import icb_pkg::*;
#(
   parameter int                                  master_n           = 4,
   parameter logic [MAX_MASTER_N*ADDR_W-1:0]      m_baseaddr         = {MAX_MASTER_N{32'h0}},
   parameter logic [MAX_MASTER_N*ADDR_W-1:0]      m_addr_range       = {MAX_MASTER_N{32'h1000}},
   parameter int                                  outstanding_depth  = 4,
   parameter bit                                  dcd_err_en         = 1'b1,
   parameter bit                                  single_target_mode = 1'b0,
   parameter int                                  simulation_delay   = 1
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [ADDR_W-1:0]           s_icb_cmd_addr,
   input  logic                        s_icb_cmd_read,
   input  logic [DATA_W-1:0]           s_icb_cmd_wdata,
   input  logic [MASK_W-1:0]           s_icb_cmd_wmask,
   input  logic                        s_icb_cmd_valid,
   output logic                        s_icb_cmd_ready,
   output logic [DATA_W-1:0]           s_icb_rsp_rdata,
   output logic                        s_icb_rsp_err,
   output logic                        s_icb_rsp_valid,
   input  logic                        s_icb_rsp_ready,
   output logic [ADDR_W*master_n-1:0]  m_icb_cmd_addr,
   output logic [master_n-1:0]         m_icb_cmd_read,
   output logic [DATA_W*master_n-1:0]  m_icb_cmd_wdata,
   output logic [MASK_W*master_n-1:0]  m_icb_cmd_wmask,
   output logic [master_n-1:0]         m_icb_cmd_valid,
   input  logic [master_n-1:0]         m_icb_cmd_ready,
   input  logic [DATA_W*master_n-1:0]  m_icb_rsp_rdata,
   input  logic [master_n-1:0]         m_icb_rsp_err,
   input  logic [master_n-1:0]         m_icb_rsp_valid,
   output logic [master_n-1:0]         m_icb_rsp_ready
);

   localparam int CNT_W = $clog2(outstanding_depth) + 1;

   // Configuration sanity; these blocks only elaborate on a bad setting.
   // simulation_delay applies to behavioural models only: the registers
   // here always update on the clock edge.
   if (master_n < 1 || master_n > MAX_MASTER_N) begin : g_bad_master_n
      $error("icb_1s_to_nm: master_n must be 1..8");
   end
   if (outstanding_depth != 2 && outstanding_depth != 4 &&
       outstanding_depth != 8 && outstanding_depth != 16) begin : g_bad_depth
      $error("icb_1s_to_nm: outstanding_depth must be 2, 4, 8 or 16");
   end
   if (simulation_delay < 0) begin : g_bad_delay
      $error("icb_1s_to_nm: simulation_delay must be non-negative");
   end

   logic [master_n-1:0] hit;
   logic [master_n-1:0] sel;
   logic [TGT_W-1:0]    tgt_idx;
   logic                miss;
   logic [ROUTE_W-1:0]  tgt_key;
   logic [ROUTE_W-1:0]  last_tgt;
   logic                stall;
   logic                push;
   logic                pop;
   route_entry_t        push_entry;
   route_entry_t        head;
   logic [ROUTE_W-1:0]  fifo_dout;
   logic                fifo_full_n;
   logic                fifo_empty_n;
   logic [CNT_W-1:0]    fifo_count;

   // Raw per-master window hits for the current command address.
   // NOTE: every combinational output gets a default first so no path
   // through the block can leave it unassigned and infer a latch.
   always_comb begin
      hit = '0;
      for (int i = 0; i < master_n; i++) begin
         hit[i] = addr_hit(s_icb_cmd_addr,
                           m_baseaddr[ADDR_W*i +: ADDR_W],
                           m_addr_range[ADDR_W*i +: ADDR_W]);
      end
   end

   // Overlap resolution: scanning downwards lets the lowest hit index win.
   always_comb begin
      sel     = '0;
      tgt_idx = '0;
      for (int i = master_n - 1; i >= 0; i--) begin
         if (hit[i]) begin
            sel     = '0;
            sel[i]  = 1'b1;
            tgt_idx = TGT_W'(i);
         end
      end
   end

   assign miss    = ~|sel;
   assign tgt_key = miss ? ERR_TGT : {1'b0, tgt_idx};

   // Hold the command when the routing FIFO is full, or, in single-target
   // mode, when it would switch away from the target still owing responses.
   assign stall = ~fifo_full_n |
                  (single_target_mode & (fifo_count != '0) & (tgt_key != last_tgt));

   // Command fields are broadcast; only the valid is steered.
   assign m_icb_cmd_addr  = {master_n{s_icb_cmd_addr}};
   assign m_icb_cmd_read  = {master_n{s_icb_cmd_read}};
   assign m_icb_cmd_wdata = {master_n{s_icb_cmd_wdata}};
   assign m_icb_cmd_wmask = {master_n{s_icb_cmd_wmask}};
   assign m_icb_cmd_valid = {master_n{s_icb_cmd_valid & ~stall}} & sel;

   assign s_icb_cmd_ready = ~stall & ((|(sel & m_icb_cmd_ready)) | (miss & dcd_err_en));
   assign push            = s_icb_cmd_valid & s_icb_cmd_ready;
   assign push_entry      = '{is_err: miss, tgt_idx: tgt_idx};

   // Most recently pushed target, compared against in single-target mode.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_tgt <= '0;
      end else if (push) begin
         last_tgt <= tgt_key;
      end
   end

   icb_route_fifo #(
      .depth (outstanding_depth),
      .width (ROUTE_W)
   ) u_route_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wen     (push),
      .din     (push_entry),
      .full_n  (fifo_full_n),
      .ren     (pop),
      .dout    (fifo_dout),
      .empty_n (fifo_empty_n),
      .count   (fifo_count)
   );

   assign head = route_entry_t'(fifo_dout);

   // Response steering from the FIFO head. Masters that are not the head
   // target see ready low, so early responses wait their turn.
   always_comb begin
      s_icb_rsp_valid = 1'b0;
      s_icb_rsp_err   = 1'b0;
      s_icb_rsp_rdata = '0;
      m_icb_rsp_ready = '0;
      if (fifo_empty_n) begin
         if (head.is_err) begin
            s_icb_rsp_valid = 1'b1;
            s_icb_rsp_err   = 1'b1;
         end else begin
            for (int i = 0; i < master_n; i++) begin
               if (head.tgt_idx == TGT_W'(i)) begin
                  s_icb_rsp_valid    = m_icb_rsp_valid[i];
                  s_icb_rsp_err      = m_icb_rsp_err[i];
                  s_icb_rsp_rdata    = m_icb_rsp_rdata[DATA_W*i +: DATA_W];
                  m_icb_rsp_ready[i] = s_icb_rsp_ready;
               end
            end
         end
      end
   end

   assign pop = s_icb_rsp_valid & s_icb_rsp_ready;

endmodule
